// File: rtl/simon_input_conditioner.sv
// simon_input_conditioner: synchronises and debounces Simon buttons/switches into clean registered pulses and levels.
module simon_input_conditioner #(
    parameter int CLK_HZ      = 50000000,
    parameter int DEBOUNCE_MS = 10,
    parameter int LONG_MS     = 1000,
    parameter int N_BTN       = 2,
    parameter int SW_W        = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] push_n,
    input  logic [SW_W-1:0]  sw,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] long_press,
    output logic [N_BTN-1:0] held,
    output logic [SW_W-1:0]  sw_stable,
    output logic [SW_W-1:0]  sw_at_press
);
    localparam int DB_CYC   = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int LONG_CYC = CLK_HZ / 1000 * LONG_MS;
    localparam int CNT_MAX  = DB_CYC > LONG_CYC ? DB_CYC : LONG_CYC;
    localparam int CW       = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYC - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
    localparam logic [CW-1:0] LONG_SAT  = CW'(LONG_CYC);

    typedef enum logic [1:0] {IDLE, DB_PRESS, PRESSED, DB_RELEASE} btn_state_e;

    logic [N_BTN-1:0] push_s1_q, push_s2_q, pressed;
    logic [SW_W-1:0]  sw_s1_q, sw_s2_q;
    btn_state_e       state_q [N_BTN];
    btn_state_e       state_d [N_BTN];
    logic [CW-1:0]    db_cnt_q [N_BTN];
    logic [CW-1:0]    db_cnt_d [N_BTN];
    logic [CW-1:0]    hold_cnt_q [N_BTN];
    logic [CW-1:0]    hold_cnt_d [N_BTN];
    logic [CW-1:0]    sw_cnt_q [SW_W];
    logic [CW-1:0]    sw_cnt_d [SW_W];
    logic [N_BTN-1:0] press_q, press_d, long_press_q, long_press_d, held_q, held_d;
    logic [SW_W-1:0]  sw_stable_q, sw_stable_d, sw_at_press_q, sw_at_press_d;

    assign pressed = ~push_s2_q;

    always_comb begin
        for (int b = 0; b < N_BTN; b++) begin
            state_d[b]      = state_q[b];
            db_cnt_d[b]     = db_cnt_q[b];
            hold_cnt_d[b]   = hold_cnt_q[b];
            press_d[b]      = 1'b0;
            long_press_d[b] = 1'b0;
            case (state_q[b])
                IDLE: begin
                    if (pressed[b]) begin
                        state_d[b]  = DB_PRESS;
                        db_cnt_d[b] = '0;
                    end
                end
                DB_PRESS: begin
                    if (!pressed[b]) begin
                        state_d[b] = IDLE;
                    end else if (db_cnt_q[b] == DB_LAST) begin
                        state_d[b]    = PRESSED;
                        press_d[b]    = 1'b1;
                        hold_cnt_d[b] = '0;
                    end else begin
                        db_cnt_d[b] = db_cnt_q[b] + CW'(1);
                    end
                end
                PRESSED: begin
                    // Saturating at LONG_CYC means LONG_CYC-1 is crossed only once per press.
                    if (hold_cnt_q[b] != LONG_SAT) begin
                        hold_cnt_d[b]   = hold_cnt_q[b] + CW'(1);
                        long_press_d[b] = (hold_cnt_q[b] + CW'(1)) == LONG_LAST;
                    end
                    if (!pressed[b]) begin
                        state_d[b]  = DB_RELEASE;
                        db_cnt_d[b] = '0;
                    end
                end
                DB_RELEASE: begin
                    if (pressed[b]) begin
                        state_d[b] = PRESSED;
                    end else if (db_cnt_q[b] == DB_LAST) begin
                        state_d[b] = IDLE;
                    end else begin
                        db_cnt_d[b] = db_cnt_q[b] + CW'(1);
                    end
                end
                default: state_d[b] = IDLE;
            endcase
            held_d[b] = (state_d[b] == PRESSED) || (state_d[b] == DB_RELEASE);
        end
        for (int i = 0; i < SW_W; i++) begin
            sw_stable_d[i] = sw_stable_q[i];
            sw_cnt_d[i]    = '0;
            if (sw_s2_q[i] != sw_stable_q[i]) begin
                if (sw_cnt_q[i] == DB_LAST) sw_stable_d[i] = sw_s2_q[i];
                else sw_cnt_d[i] = sw_cnt_q[i] + CW'(1);
            end
        end
        // Capture the pre-update value so a coincident switch change is not seen.
        sw_at_press_d = press_d[0] ? sw_stable_q : sw_at_press_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_s1_q     <= '1;
            push_s2_q     <= '1;
            sw_s1_q       <= '0;
            sw_s2_q       <= '0;
            press_q       <= '0;
            long_press_q  <= '0;
            held_q        <= '0;
            sw_stable_q   <= '0;
            sw_at_press_q <= '0;
            for (int b = 0; b < N_BTN; b++) begin
                state_q[b]    <= IDLE;
                db_cnt_q[b]   <= '0;
                hold_cnt_q[b] <= '0;
            end
            for (int i = 0; i < SW_W; i++) sw_cnt_q[i] <= '0;
        end else begin
            push_s1_q     <= push_n;
            push_s2_q     <= push_s1_q;
            sw_s1_q       <= sw;
            sw_s2_q       <= sw_s1_q;
            press_q       <= press_d;
            long_press_q  <= long_press_d;
            held_q        <= held_d;
            sw_stable_q   <= sw_stable_d;
            sw_at_press_q <= sw_at_press_d;
            for (int b = 0; b < N_BTN; b++) begin
                state_q[b]    <= state_d[b];
                db_cnt_q[b]   <= db_cnt_d[b];
                hold_cnt_q[b] <= hold_cnt_d[b];
            end
            for (int i = 0; i < SW_W; i++) sw_cnt_q[i] <= sw_cnt_d[i];
        end
    end

    assign press       = press_q;
    assign long_press  = long_press_q;
    assign held        = held_q;
    assign sw_stable   = sw_stable_q;
    assign sw_at_press = sw_at_press_q;
endmodule

// File: tb/tb_simon_input_conditioner.sv
// tb_simon_input_conditioner: scoreboard bench with DB_CYC=4, LONG_CYC=10.
module tb_simon_input_conditioner;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] push_n;
    logic [5:0] sw;
    logic [1:0] press, long_press, held;
    logic [5:0] sw_stable, sw_at_press;

    always #5 clk = ~clk;

    simon_input_conditioner #(
        .CLK_HZ(1000), .DEBOUNCE_MS(4), .LONG_MS(10), .N_BTN(2), .SW_W(6)
    ) dut (
        .clk(clk), .rst_n(rst_n), .push_n(push_n), .sw(sw),
        .press(press), .long_press(long_press), .held(held),
        .sw_stable(sw_stable), .sw_at_press(sw_at_press)
    );

    typedef struct {
        int         c;
        logic [1:0] p, l, h;
        logic [5:0] ss, sa;
        bit         cl, cs;
    } exp_t;

    exp_t  sb[$];
    string scen;
    int    tests = 0;
    int    fails = 0;
    int    lp_n  = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(int c, logic [1:0] p, logic [1:0] l, logic [1:0] h,
                                logic [5:0] ss, logic [5:0] sa, bit cl, bit cs);
        exp_t e;
        e.c = c; e.p = p; e.l = l; e.h = h; e.ss = ss; e.sa = sa; e.cl = cl; e.cs = cs;
        return e;
    endfunction

    task automatic step(exp_t e_in);
        exp_t e;
        sb.push_back(e_in);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check($sformatf("%s c%0d press", scen, e.c), 32'(press), 32'(e.p));
        check($sformatf("%s c%0d held", scen, e.c), 32'(held), 32'(e.h));
        if (e.cl) check($sformatf("%s c%0d long_press", scen, e.c), 32'(long_press), 32'(e.l));
        if (e.cs) begin
            check($sformatf("%s c%0d sw_stable", scen, e.c), 32'(sw_stable), 32'(e.ss));
            check($sformatf("%s c%0d sw_at_press", scen, e.c), 32'(sw_at_press), 32'(e.sa));
        end
    endtask

    task automatic check_zero(string tag);
        check({tag, " press"}, 32'(press), 32'd0);
        check({tag, " long_press"}, 32'(long_press), 32'd0);
        check({tag, " held"}, 32'(held), 32'd0);
        check({tag, " sw_stable"}, 32'(sw_stable), 32'd0);
        check({tag, " sw_at_press"}, 32'(sw_at_press), 32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        push_n = 2'b11;
        sw     = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        scen = "clean";
        for (int c = 0; c < 30; c++) begin
            push_n[0] = c >= 20;
            step(mk(c, {1'b0, c == 6}, {1'b0, c == 15}, {1'b0, c >= 6 && c <= 25},
                    6'd0, 6'd0, 1'b1, 1'b1));
        end

        scen = "bounce";
        for (int c = 0; c < 33; c++) begin
            push_n[1] = (c == 2) || (c >= 23);
            step(mk(c, {c == 9, 1'b0}, {c == 18, 1'b0}, {c >= 9 && c <= 28, 1'b0},
                    6'd0, 6'd0, 1'b1, 1'b1));
        end

        scen = "glitch";
        for (int c = 0; c < 35; c++) begin
            push_n[0] = (c == 10) || (c == 11) || (c >= 25);
            step(mk(c, {1'b0, c == 6}, 2'b00, {1'b0, c >= 6 && c <= 30},
                    6'd0, 6'd0, 1'b0, 1'b1));
            if (long_press[0]) lp_n++;
        end
        check("glitch long_press count", 32'(lp_n), 32'd1);

        scen = "snap";
        for (int c = -10; c < 48; c++) begin
            sw        = (c >= 8) ? 6'b000011 : 6'b101101;
            push_n[0] = !((c >= 0 && c < 20) || (c >= 30 && c < 40));
            step(mk(c, {1'b0, c == 6 || c == 36}, {1'b0, c == 15},
                    {1'b0, (c >= 6 && c <= 25) || (c >= 36 && c <= 45)},
                    (c < -5) ? 6'd0 : (c < 13) ? 6'b101101 : 6'b000011,
                    (c < 6) ? 6'd0 : (c < 36) ? 6'b101101 : 6'b000011, 1'b1, 1'b1));
        end

        scen = "simul";
        for (int c = 0; c < 21; c++) begin
            push_n = (c >= 10) ? 2'b11 : 2'b00;
            step(mk(c, (c == 6) ? 2'b11 : 2'b00, 2'b00,
                    (c >= 6 && c <= 15) ? 2'b11 : 2'b00,
                    6'b000011, 6'b000011, 1'b1, 1'b1));
        end

        scen = "reset";
        for (int c = -10; c < 35; c++) begin
            push_n[1] = c >= 26;
            push_n[0] = !(c >= 0 && c < 26);
            if (c == 4) begin
                rst_n = 1'b0;
                #1;
                check_zero("async reset");
            end
            if (c == 8) rst_n = 1'b1;
            step(mk(c, (c == -4) ? 2'b10 : (c == 14) ? 2'b11 : 2'b00,
                    (c == 23) ? 2'b11 : 2'b00,
                    (c >= -4 && c < 4) ? 2'b10 : (c >= 14 && c <= 31) ? 2'b11 : 2'b00,
                    (c >= 4 && c < 13) ? 6'd0 : 6'b000011,
                    (c >= 4 && c < 14) ? 6'd0 : 6'b000011, 1'b1, 1'b1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
